// File: rtl/timer_periph.sv
// Memory-mapped 32-bit timer: prescaled up-counter with compare match,
// optional auto-reload, overflow flag and a level interrupt.
module timer_periph #(
    parameter int unsigned PRESC_W = 16,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_timer_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

    localparam logic [2:0] RegCtrl    = 3'd0;
    localparam logic [2:0] RegPresc   = 3'd1;
    localparam logic [2:0] RegCount   = 3'd2;
    localparam logic [2:0] RegCompare = 3'd3;
    localparam logic [2:0] RegStatus  = 3'd4;

    logic               en_q, auto_reload_q, irq_en_q;
    logic [PRESC_W-1:0] presc_q, psc_cnt_q, psc_cnt_d;
    logic [31:0]        count_q, count_d, compare_q;
    logic               match_q, match_d, ovf_q, ovf_d;

    logic       in_range;
    logic [2:0] reg_idx;
    logic       wr, wr_ctrl, wr_presc, wr_count, wr_compare, wr_status;
    logic       tick, set_match, set_ovf;
    logic       unused_bits;

    // Only the first five words are backed; everything above reads as zero.
    assign reg_idx  = addr[4:2];
    assign in_range = (addr[ADDR_W-1:5] == '0) && (reg_idx <= RegStatus);

    assign wr         = !cs_timer_n && we && in_range;
    assign wr_ctrl    = wr && (reg_idx == RegCtrl);
    assign wr_presc   = wr && (reg_idx == RegPresc);
    assign wr_count   = wr && (reg_idx == RegCount);
    assign wr_compare = wr && (reg_idx == RegCompare);
    assign wr_status  = wr && (reg_idx == RegStatus);

    assign tick = en_q && (psc_cnt_q == presc_q);

    // A software COUNT write pre-empts match/overflow evaluation.
    assign set_match = tick && !wr_count && (count_q == compare_q);
    assign set_ovf   = tick && !wr_count && !(count_q == compare_q) && (count_q == 32'hFFFF_FFFF);

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (wr_presc || !en_q || tick) begin
            psc_cnt_d = '0;
        end else begin
            psc_cnt_d = psc_cnt_q + 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (wr_count) begin
            count_d = wdata;
        end else if (tick) begin
            if (set_match && auto_reload_q) begin
                count_d = 32'd0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    // Hardware set beats a same-cycle write-1-to-clear.
    assign match_d = set_match | (match_q & ~(wr_status & wdata[0]));
    assign ovf_d   = set_ovf   | (ovf_q   & ~(wr_status & wdata[1]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q          <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            presc_q       <= '0;
            psc_cnt_q     <= '0;
            count_q       <= 32'd0;
            compare_q     <= 32'd0;
            match_q       <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q          <= wdata[0];
                auto_reload_q <= wdata[1];
                irq_en_q      <= wdata[2];
            end
            if (wr_presc) begin
                presc_q <= wdata[PRESC_W-1:0];
            end
            if (wr_compare) begin
                compare_q <= wdata;
            end
            psc_cnt_q <= psc_cnt_d;
            count_q   <= count_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (!cs_timer_n && in_range) begin
            unique case (reg_idx)
                RegCtrl:    rdata = {29'd0, irq_en_q, auto_reload_q, en_q};
                RegPresc:   rdata = 32'(presc_q);
                RegCount:   rdata = count_q;
                RegCompare: rdata = compare_q;
                RegStatus:  rdata = {30'd0, ovf_q, match_q};
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign irq = irq_en_q & (match_q | ovf_q);

    assign unused_bits = ^{addr[1:0], wdata};

endmodule

// File: doc/timer_periph.md
Name: timer_periph

Overview:
- Memory-mapped 32-bit timer peripheral.
- Responder on the data bus for the region 0x80001000–0x80001FFF.
- Selected by the active-low chip select cs_timer_n that the address decoder drives.
- Provides a prescaled up-counter, a compare match with optional auto-reload, overflow detection, and a level interrupt to the core.

Parameters:
- PRESC_W, 16, width of the prescaler register and prescaler counter.
- ADDR_W, 12, width of the offset address inside the timer region.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs_timer_n  input  1  active-low chip select from the address decoder.
- we  input  1  write strobe; qualified by cs_timer_n=0.
- addr  input  ADDR_W  byte offset within the region; addr[4:2] selects the register, addr[1:0] is ignored.
- wdata  input  32  write data (full-word writes only).
- rdata  output  32  read data; combinational from register state; 0 when cs_timer_n=1.
- irq  output  1  level interrupt; equals ctrl.irq_en & (status.match | status.ovf).

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: bit0 en, bit1 auto_reload, bit2 irq_en; bits 31:3 read 0.
  - 0x04 PRESCALE: bits PRESC_W-1:0.
  - 0x08 COUNT: 32-bit counter.
  - 0x0C COMPARE: 32-bit compare value.
  - 0x10 STATUS: bit0 match, bit1 ovf; write-1-to-clear.
  - Offsets 0x14–0xFFC: read 0; writes ignored.
- Bus access:
  - A write takes effect at the clock edge where cs_timer_n=0 and we=1.
  - Reads are zero-wait-state: rdata is valid in the same cycle cs_timer_n=0 and we=0.
  - No read side effects.
- Reset: all registers 0, internal prescaler counter 0, irq=0, rdata=0.
- Prescaler:
  - psc_cnt counts 0..PRESCALE while en=1.
  - tick is asserted in the cycle psc_cnt==PRESCALE; psc_cnt then returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - en=0 holds psc_cnt at 0 and suppresses ticks.
  - A write to PRESCALE also clears psc_cnt.
- Counter on tick:
  - If COUNT==COMPARE: set status.match. Next COUNT = 0 if auto_reload=1, else COUNT+1.
  - Else if COUNT==0xFFFFFFFF: set status.ovf; COUNT wraps to 0.
  - Else: COUNT+1.
  - With auto_reload=1, the match period is (COMPARE+1)*(PRESCALE+1) cycles.
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick: the written value wins; no match or ovf evaluation that cycle.
  - A W1C of a status bit in the same cycle that hardware sets it: the set wins (bit stays 1).
  - Writing COMPARE takes effect for the next tick.
- Enable:
  - Clearing en freezes COUNT and flags.
  - Re-enabling resumes from the frozen COUNT with psc_cnt=0.
- Reset mid-operation: asynchronous assertion forces all state to reset values immediately. Deassertion is assumed to be synchronised upstream.
- Interrupt:
  - irq is combinational from flops, so there is no glitch path from bus inputs.
  - It deasserts in the cycle after the W1C edge that clears the last pending enabled flag.

Test Plan:
- Reset check: assert rst_n=0 mid-count with irq=1 -> irq=0 and all registers read 0 immediately after release.
- Free-run count: PRESCALE=0, COMPARE=5, CTRL=0b111 -> COUNT sequence 0..5,0..; match and irq set on the 6th tick (cycle 6 after enable); period is 6 cycles.
- Prescaled count: PRESCALE=3, auto_reload=0 -> COUNT increments every 4 cycles; COUNT=2 after 8 enabled cycles.
- Overflow: write COUNT=0xFFFFFFFE, COMPARE=0x10, en=1, PRESCALE=0 -> after 2 ticks COUNT=0 and status=0b10; irq=1 only if irq_en=1.
- W1C and collisions:
  - Write STATUS=0x1 in the exact cycle a new match occurs -> match remains 1.
  - Write STATUS=0x1 on a quiet cycle -> match=0 and irq falls next cycle.
  - Write COUNT=0x100 on a tick cycle -> COUNT reads 0x100.
- Decode gating:
  - cs_timer_n=1 with we=1, addr=0x08 -> COUNT unchanged, rdata=0.
  - Read of offset 0x20 -> 0.
